inst_loader: RTL and testbench

//  Writer side of the instruction memory: accepts a byte stream (valid/ready) carrying a

---
 rtl/inst_loader_pkg.sv | 30 +++
 rtl/inst_loader_if.sv | 34 +++
 rtl/inst_loader.sv | 156 +++++++++++++++
 tb/tb_inst_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg -- shared types and constants for the instruction loader.
//   ld_state_e      : loader FSM states
//   INST_A / INST_W : default address / word widths
//   LEN_BYTES / WORD_BYTES : stream framing sizes
//   hi_unused_mask  : bits of the HI byte that carry no word data for width w
package inst_loader_pkg;

  localparam int INST_A     = 10;
  localparam int INST_W     = 9;
  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    CKSUM   = 3'd5,
    DONE    = 3'd6
  } ld_state_e;

  function automatic logic [7:0] hi_unused_mask(input int w);
    logic [7:0] m;
    m = 8'hFF;
    if (w > 8) m = 8'(8'hFF << (w - 8));
    return m;
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if -- host stream, session status and instruction RAM write port.
//   Start / InByte / InValid   : host -> loader
//   InReady                    : loader -> host
//   InstWrEn/Addr/Data         : loader -> instruction RAM
//   Busy / Done / Err / WordCount : session status
// Modports: master = host/RAM side, slave = loader.
interface inst_loader_if
  import inst_loader_pkg::*;
#(
  parameter int A = INST_A,
  parameter int W = INST_W
);
  logic         Start;
  logic [7:0]   InByte;
  logic         InValid;
  logic         InReady;
  logic         InstWrEn;
  logic [A-1:0] InstWrAddr;
  logic [W-1:0] InstWrData;
  logic         Busy;
  logic         Done;
  logic         Err;
  logic [A:0]   WordCount;

  modport master (
    output Start, InByte, InValid,
    input  InReady, InstWrEn, InstWrAddr, InstWrData, Busy, Done, Err, WordCount
  );

  modport slave (
    input  Start, InByte, InValid,
    output InReady, InstWrEn, InstWrAddr, InstWrData, Busy, Done, Err, WordCount
  );
endinterface

// File: rtl/inst_loader.sv
// inst_loader -- writes a length-prefixed byte stream of W-bit words into
// instruction RAM starting at address 0.
// Ports:
//   Clk      : clock, all state on posedge
//   Reset_n  : synchronous active-low reset
//   bus      : inst_loader_if.slave (stream in, RAM write port, status out)
// Stream: LEN_LO, LEN_HI, then per word LO = data[7:0], HI = data[W-1:8].
// Optional feature macro: INST_LOADER_CKSUM_EN -- expects a trailing byte equal
// to the XOR of all length and data bytes; mismatch sets Err.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int A = INST_A,
  parameter int W = INST_W
) (
  input logic         Clk,
  input logic         Reset_n,
  inst_loader_if.slave bus
);

  localparam logic [16:0] DEPTH   = 17'(1) << A;
  localparam logic [7:0]  HI_MASK = hi_unused_mask(W);

  ld_state_e    r_state;
  logic [15:0]  r_len;
  logic [7:0]   r_lo;
  logic [A-1:0] r_ptr;
  logic [A:0]   r_cnt;
  logic         r_wr_en;
  logic [A-1:0] r_wr_addr;
  logic [W-1:0] r_wr_data;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
`ifdef INST_LOADER_CKSUM_EN
  logic [7:0]   r_xor;
`endif

  logic        w_ready;
  logic        w_xfer;
  logic [15:0] w_len_full;
  logic        w_too_long;
  logic        w_last;
  logic        w_hi_bad;

  assign w_ready    = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == DATA_LO) || (r_state == DATA_HI) ||
                      (r_state == CKSUM);
  assign w_xfer     = bus.InValid & w_ready;
  assign w_len_full = {bus.InByte, r_len[7:0]};
  assign w_too_long = {1'b0, w_len_full} > DEPTH;
  // the word being written now is word N
  assign w_last     = (17'(r_cnt) + 17'd1) == {1'b0, r_len};
  assign w_hi_bad   = |(bus.InByte & HI_MASK);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_lo      <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef INST_LOADER_CKSUM_EN
      r_xor     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
`ifdef INST_LOADER_CKSUM_EN
      if (w_xfer && r_state != CKSUM) r_xor <= r_xor ^ bus.InByte;
`endif
      case (r_state)
        IDLE, DONE: begin
          // Busy drops and Done rises one cycle after entering DONE, so Done
          // trails the final InstWrEn by one cycle. Start is ignored until then.
          if (r_busy) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else if (bus.Start) begin
            r_state <= LEN_LO;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_ptr   <= '0;
`ifdef INST_LOADER_CKSUM_EN
            r_xor   <= '0;
`endif
          end
        end
        LEN_LO: if (w_xfer) begin
          r_len[7:0] <= bus.InByte;
          r_state    <= LEN_HI;
        end
        LEN_HI: if (w_xfer) begin
          r_len[15:8] <= bus.InByte;
          if (w_too_long) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else if (w_len_full == 16'd0) begin
`ifdef INST_LOADER_CKSUM_EN
            r_state <= CKSUM;
`else
            r_state <= DONE;
`endif
          end else begin
            r_state <= DATA_LO;
          end
        end
        DATA_LO: if (w_xfer) begin
          r_lo    <= bus.InByte;
          r_state <= DATA_HI;
        end
        DATA_HI: if (w_xfer) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_ptr;
          r_wr_data <= W'({bus.InByte, r_lo});
          r_ptr     <= r_ptr + 1'b1;
          r_cnt     <= r_cnt + 1'b1;
          if (w_hi_bad) r_err <= 1'b1;
          if (w_last) begin
`ifdef INST_LOADER_CKSUM_EN
            r_state <= CKSUM;
`else
            r_state <= DONE;
`endif
          end else begin
            r_state <= DATA_LO;
          end
        end
`ifdef INST_LOADER_CKSUM_EN
        CKSUM: if (w_xfer) begin
          if (bus.InByte != r_xor) r_err <= 1'b1;
          r_state <= DONE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.InReady    = w_ready;
  assign bus.InstWrEn   = r_wr_en;
  assign bus.InstWrAddr = r_wr_addr;
  assign bus.InstWrData = r_wr_data;
  assign bus.Busy       = r_busy;
  assign bus.Done       = r_done;
  assign bus.Err        = r_err;
  assign bus.WordCount  = r_cnt;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader -- directed bench for inst_loader (A=10, W=9).
// Inputs are driven and outputs sampled on the falling edge.
module tb_inst_loader;
  import inst_loader_pkg::*;

  typedef logic [7:0] bq_t [$];

  logic Clk;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [9:0] wr_addr [$];
  logic [8:0] wr_data [$];
  logic [8:0] rom [0:1023];

  inst_loader_if #(.A(10), .W(9)) bus ();

  inst_loader #(.A(10), .W(9)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // RAM model: capture every write, also used for readback
  always @(negedge Clk) begin
    if (bus.InstWrEn === 1'b1) begin
      wr_addr.push_back(bus.InstWrAddr);
      wr_data.push_back(bus.InstWrData);
      rom[bus.InstWrAddr] = bus.InstWrData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // entered and left on a falling edge
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int t;
    if (stall) begin
      bus.InValid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    bus.InByte  = b;
    bus.InValid = 1'b1;
    t = 0;
    while (!bus.InReady && t < 40) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 40) chk("rdy_timeout", 32'(bus.InReady), 32'd1);
    @(negedge Clk);
    bus.InValid = 1'b0;
  endtask

  task automatic send_seq(input bq_t q, input bit stall);
    foreach (q[i]) send_byte(q[i], stall);
  endtask

  task automatic start_pulse();
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  function automatic logic [7:0] xor_of(input bq_t q);
    logic [7:0] x;
    x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  function automatic bq_t with_ck(input bq_t q);
    bq_t r;
    r = q;
`ifdef INST_LOADER_CKSUM_EN
    r.push_back(xor_of(q));
`endif
    return r;
  endfunction

  task automatic chk_case1_writes(input string tag);
    logic [8:0] exp [3];
    exp = '{9'h112, 9'h034, 9'h1FF};
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_addr"}, (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hxxxx_xxxx, 32'(i));
      chk({tag, "_data"}, (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hxxxx_xxxx, 32'(exp[i]));
      chk({tag, "_rom"}, 32'(rom[i]), 32'(exp[i]));
    end
  endtask

  bq_t c1 = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};

  initial begin
    bus.Start   = 1'b0;
    bus.InByte  = 8'h00;
    bus.InValid = 1'b0;
    Reset_n     = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_busy",  32'(bus.Busy), 32'd0);
    chk("rst_done",  32'(bus.Done), 32'd0);
    chk("rst_err",   32'(bus.Err), 32'd0);
    chk("rst_rdy",   32'(bus.InReady), 32'd0);
    chk("rst_wren",  32'(bus.InstWrEn), 32'd0);
    chk("rst_wcnt",  32'(bus.WordCount), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("idle_rdy", 32'(bus.InReady), 32'd0);

    // 1: three words at full rate
    wr_addr.delete(); wr_data.delete();
    start_pulse();
    chk("c1_busy", 32'(bus.Busy), 32'd1);
    chk("c1_rdy",  32'(bus.InReady), 32'd1);
    send_seq(with_ck(c1), 1'b0);
`ifndef INST_LOADER_CKSUM_EN
    chk("c1_lastwr", 32'(bus.InstWrEn), 32'd1);
`endif
    chk("c1_done_early", 32'(bus.Done), 32'd0);
    @(negedge Clk);
    chk("c1_done", 32'(bus.Done), 32'd1);
    chk("c1_busy_end", 32'(bus.Busy), 32'd0);
    chk("c1_err",  32'(bus.Err), 32'd0);
    chk("c1_wcnt", 32'(bus.WordCount), 32'd3);
    chk("c1_rdy_done", 32'(bus.InReady), 32'd0);
    chk_case1_writes("c1");

    // 2: zero-length session
    wr_addr.delete(); wr_data.delete();
    start_pulse();
    chk("c2_done_clr", 32'(bus.Done), 32'd0);
    send_seq(with_ck('{8'h00, 8'h00}), 1'b0);
    @(negedge Clk);
    chk("c2_done", 32'(bus.Done), 32'd1);
    chk("c2_err",  32'(bus.Err), 32'd0);
    chk("c2_nwr",  32'(wr_addr.size()), 32'd0);
    chk("c2_wcnt", 32'(bus.WordCount), 32'd0);

    // 3: length 1025 exceeds depth
    start_pulse();
    send_seq('{8'h01, 8'h04}, 1'b0);
    @(negedge Clk);
    chk("c3_done", 32'(bus.Done), 32'd1);
    chk("c3_err",  32'(bus.Err), 32'd1);
    chk("c3_rdy",  32'(bus.InReady), 32'd0);
    repeat (2) @(negedge Clk);
    chk("c3_nwr",  32'(wr_addr.size()), 32'd0);

    // 4: nonzero unused HI bits -> truncated write, Err
    start_pulse();
    chk("c4_err_clr", 32'(bus.Err), 32'd0);
    send_seq(with_ck('{8'h01, 8'h00, 8'h55, 8'h03}), 1'b0);
    @(negedge Clk);
    chk("c4_done", 32'(bus.Done), 32'd1);
    chk("c4_err",  32'(bus.Err), 32'd1);
    chk("c4_wcnt", 32'(bus.WordCount), 32'd1);
    chk("c4_nwr",  32'(wr_data.size()), 32'd1);
    chk("c4_data", (wr_data.size() > 0) ? 32'(wr_data[0]) : 32'hxxxx_xxxx, 32'h155);

    // 5a: random stalls and a Start pulse while Busy
    wr_addr.delete(); wr_data.delete();
    start_pulse();
    begin
      bq_t q;
      q = with_ck(c1);
      foreach (q[i]) begin
        if (i == 4) begin
          start_pulse();
          chk("c5_busy_hold", 32'(bus.Busy), 32'd1);
          chk("c5_wcnt_mid",  32'(bus.WordCount), 32'd1);
        end
        send_byte(q[i], 1'b1);
      end
    end
    @(negedge Clk);
    chk("c5_done", 32'(bus.Done), 32'd1);
    chk("c5_err",  32'(bus.Err), 32'd0);
    chk_case1_writes("c5");

    // 5b: reset lands on the edge that would register the third write
    wr_addr.delete(); wr_data.delete();
    start_pulse();
    send_seq('{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF}, 1'b0);
    chk("c5r_wcnt_pre", 32'(bus.WordCount), 32'd2);
    bus.InByte  = 8'h01;
    bus.InValid = 1'b1;
    Reset_n     = 1'b0;
    @(negedge Clk);
    bus.InValid = 1'b0;
    chk("c5r_wren", 32'(bus.InstWrEn), 32'd0);
    chk("c5r_busy", 32'(bus.Busy), 32'd0);
    chk("c5r_done", 32'(bus.Done), 32'd0);
    chk("c5r_wcnt", 32'(bus.WordCount), 32'd0);
    chk("c5r_rdy",  32'(bus.InReady), 32'd0);
    repeat (3) @(negedge Clk);
    chk("c5r_nwr",  32'(wr_addr.size()), 32'd2);
    Reset_n = 1'b1;
    @(negedge Clk);

`ifdef INST_LOADER_CKSUM_EN
    // 6: bad checksum byte
    start_pulse();
    begin
      bq_t q;
      q = c1;
      q.push_back(xor_of(c1) ^ 8'hDA ^ 8'h00 ^ xor_of(c1) ^ 8'hDA ^ 8'h00 ^ 8'h00);
      q[q.size()-1] = (xor_of(c1) == 8'h00) ? 8'h01 : 8'h00;
      send_seq(q, 1'b0);
    end
    @(negedge Clk);
    chk("c6_done", 32'(bus.Done), 32'd1);
    chk("c6_err",  32'(bus.Err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
